// File: rtl/reflet_irq_ctrl_if.sv
// CPU data-bus view of the interrupt controller: address, write strobe,
// write data, stall/enable and the registered read-back path.
interface reflet_irq_ctrl_if #(
   parameter int wordsize = 8
);
   logic                enable;
   logic [wordsize-1:0] addr;
   logic [wordsize-1:0] data_in;
   logic                write_en;
   logic [wordsize-1:0] data_out;

   // CPU side drives the bus and samples read data
   modport master (
      output enable,
      output addr,
      output data_in,
      output write_en,
      input  data_out
   );

   // Controller side decodes the bus and returns read data
   modport slave (
      input  enable,
      input  addr,
      input  data_in,
      input  write_en,
      output data_out
   );
endinterface

// File: rtl/reflet_irq_ctrl.sv
// Eight-source interrupt controller feeding the four CPU request lines.
// Each source is synchronised, optionally edge-detected, latched into a
// pending bit, masked and OR-ed in pairs onto one request line.
module reflet_irq_ctrl #(
   parameter int wordsize  = 8,
   parameter int base_addr = 'hF0
) (
   input  logic                clk,
   input  logic                reset,
   reflet_irq_ctrl_if.slave    bus,
   input  logic [7:0]          irq_src,
   output logic [3:0]          interrupt_request
);

   localparam logic [wordsize-1:0] BASE = wordsize'(base_addr);

   logic [7:0]          s1_q, s2_q, s3_q;
   logic [7:0]          pending_q, pending_d;
   logic [7:0]          mask_q, mask_d;
   logic [7:0]          mode_q, mode_d;
   logic [3:0]          irq_q, irq_d;
   logic [wordsize-1:0] dout_q, dout_d;

   logic [3:0] hit;
   logic       wr;
   logic [7:0] set_vec;
   logic [7:0] clr_vec;
   logic [7:0] active;
   logic [2:0] low_idx;
   logic [7:0] status;

   // One decode line per register offset; base need not be 4-aligned
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_hit
         assign hit[gi] = (bus.addr == BASE + wordsize'(gi));
      end
   endgenerate

   assign wr      = bus.write_en & bus.enable;
   assign set_vec = (mode_q & s2_q & ~s3_q) | (~mode_q & s2_q);
   assign clr_vec = (wr & hit[0]) ? bus.data_in[7:0] : 8'h00;
   assign active  = pending_q & mask_q;

   // Lowest-index active source for the STATUS register
   always_comb begin
      low_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (active[i]) low_idx = 3'(i);
      end
   end

   assign status = {|active, 4'b0000, low_idx};

   // Pending/mask/mode next state; a coincident set beats a clear
   always_comb begin
      pending_d = set_vec | (pending_q & ~clr_vec);
      mask_d    = (wr & hit[1]) ? bus.data_in[7:0] : mask_q;
      mode_d    = (wr & hit[2]) ? bus.data_in[7:0] : mode_q;
   end

   // Each request line is the masked OR of one adjacent source pair
   generate
      for (gi = 0; gi < 4; gi++) begin : g_route
         assign irq_d[gi] = |active[2*gi+1:2*gi];
      end
   endgenerate

   // Read mux; unselected addresses return zero so the bus can be OR-ed
   always_comb begin
      dout_d = '0;
      if (hit[0]) dout_d = wordsize'(pending_q);
      if (hit[1]) dout_d = wordsize'(mask_q);
      if (hit[2]) dout_d = wordsize'(mode_q);
      if (hit[3]) dout_d = wordsize'(status);
   end

   // All state registers; reset discards every captured event
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q      <= 8'h00;
         s2_q      <= 8'h00;
         s3_q      <= 8'h00;
         pending_q <= 8'h00;
         mask_q    <= 8'h00;
         mode_q    <= 8'h00;
         irq_q     <= 4'h0;
         dout_q    <= '0;
      end else begin
         s1_q      <= irq_src;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         mode_q    <= mode_d;
         irq_q     <= irq_d;
         dout_q    <= dout_d;
      end
   end

   assign interrupt_request = irq_q;
   assign bus.data_out      = dout_q;

endmodule

// File: tb/tb_reflet_irq_ctrl.sv
// Directed bench for reflet_irq_ctrl: reset values, edge capture, level
// re-pend, masking/priority, stalled CPU, set/clear collision, mid-op reset.
module tb_reflet_irq_ctrl;

   localparam logic [7:0] A_PEND = 8'hF0;
   localparam logic [7:0] A_MASK = 8'hF1;
   localparam logic [7:0] A_MODE = 8'hF2;
   localparam logic [7:0] A_STAT = 8'hF3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] irq_src = 8'h00;
   logic [3:0] interrupt_request;
   logic [7:0] rd;

   int vectors = 0;
   int miscompares = 0;

   reflet_irq_ctrl_if #(.wordsize(8)) bus ();

   reflet_irq_ctrl #(.wordsize(8), .base_addr('hF0)) dut (
      .clk               (clk),
      .reset             (reset),
      .bus               (bus.slave),
      .irq_src           (irq_src),
      .interrupt_request (interrupt_request)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Single-cycle write: the write lands on the next rising edge
   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.addr     = a;
      bus.data_in  = d;
      bus.write_en = 1'b1;
      @(posedge clk);
      #1;
      bus.write_en = 1'b0;
      bus.addr     = 8'h00;
      bus.data_in  = 8'h00;
   endtask

   // Present address, sample registered read data after the next edge
   task automatic rdreg(input logic [7:0] a, output logic [7:0] d);
      bus.addr = a;
      @(posedge clk);
      #1;
      d = bus.data_out;
      bus.addr = 8'h00;
   endtask

   initial begin
      bus.enable   = 1'b1;
      bus.addr     = A_MASK;
      bus.data_in  = 8'hFF;
      bus.write_en = 1'b0;

      // Reset held: activity must not reach any output
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         irq_src      = ~irq_src;
         bus.write_en = ~bus.write_en;
      end
      #1;
      check("rst_irq", {4'h0, interrupt_request}, 8'h00);
      check("rst_dout", bus.data_out, 8'h00);
      @(negedge clk);
      irq_src      = 8'h00;
      bus.write_en = 1'b0;
      bus.addr     = 8'h00;
      reset        = 1'b1;
      rdreg(A_PEND, rd); check("rst_pend", rd, 8'h00);
      rdreg(A_MASK, rd); check("rst_mask", rd, 8'h00);
      rdreg(A_MODE, rd); check("rst_mode", rd, 8'h00);
      rdreg(A_STAT, rd); check("rst_stat", rd, 8'h00);

      // Edge capture on source 0
      wr(A_MODE, 8'hFF);
      wr(A_MASK, 8'h01);
      @(negedge clk);
      irq_src[0] = 1'b1;
      @(posedge clk);             // edge N
      tick(1); check("edge_n1", {4'h0, interrupt_request}, 8'h00);
      tick(1); check("edge_n2", {4'h0, interrupt_request}, 8'h00);
      tick(1); check("edge_n3", {4'h0, interrupt_request}, 8'h01);
      tick(17);
      rdreg(A_PEND, rd); check("edge_pend", rd, 8'h01);
      wr(A_PEND, 8'h01);
      tick(1); check("edge_clr", {4'h0, interrupt_request}, 8'h00);
      tick(4); check("edge_norepend", {4'h0, interrupt_request}, 8'h00);
      rdreg(A_PEND, rd); check("edge_pend0", rd, 8'h00);

      // Level source 7 re-pends while held high
      irq_src = 8'h00;
      tick(4);
      wr(A_MODE, 8'h00);
      wr(A_MASK, 8'h80);
      wr(A_PEND, 8'hFF);
      @(negedge clk);
      irq_src[7] = 1'b1;
      tick(5); check("lvl_irq", {4'h0, interrupt_request}, 8'h08);
      wr(A_PEND, 8'h80);
      tick(2); check("lvl_irq_after", {4'h0, interrupt_request}, 8'h08);
      rdreg(A_PEND, rd); check("lvl_repend", rd, 8'h80);

      // Masking and priority with sources 2 and 5
      irq_src = 8'h00;
      wr(A_MODE, 8'hFF);
      tick(4);
      wr(A_PEND, 8'hFF);
      wr(A_MASK, 8'h20);
      @(negedge clk);
      irq_src = 8'h24;
      tick(3);
      irq_src = 8'h00;
      tick(5);
      rdreg(A_STAT, rd); check("prio_stat1", rd, 8'h85);
      check("prio_irq1", {4'h0, interrupt_request}, 8'h04);
      wr(A_MASK, 8'h24);
      tick(1); check("prio_irq2", {4'h0, interrupt_request}, 8'h06);
      rdreg(A_STAT, rd); check("prio_stat2", rd, 8'h82);

      // Stalled CPU: events still pend, writes suppressed
      wr(A_PEND, 8'hFF);
      @(negedge clk);
      bus.enable = 1'b0;
      irq_src[1] = 1'b1;
      tick(5);
      irq_src[1] = 1'b0;
      wr(A_MASK, 8'hFF);
      wr(A_PEND, 8'hFF);
      tick(3);
      rdreg(A_MASK, rd); check("stall_mask", rd, 8'h24);
      @(negedge clk);
      bus.enable = 1'b1;
      rdreg(A_PEND, rd); check("stall_pend", rd, 8'h02);
      rdreg(A_MASK, rd); check("stall_mask2", rd, 8'h24);

      // Unmatched address reads zero and writes nothing
      wr(8'h10, 8'hFF);
      rdreg(8'hF4, rd); check("nomatch_rd", rd, 8'h00);
      rdreg(A_MASK, rd); check("nomatch_mask", rd, 8'h24);

      // Clear-write coinciding with a new edge on source 3: set wins
      wr(A_PEND, 8'hFF);
      tick(2);
      @(negedge clk);
      irq_src[3] = 1'b1;
      @(posedge clk);             // edge N
      tick(1);                    // edge N+1
      wr(A_PEND, 8'h08);          // lands on N+2 with rise active
      rdreg(A_PEND, rd); check("coll_pend", rd, 8'h08);
      wr(A_MASK, 8'h08);
      tick(1); check("coll_irq", {4'h0, interrupt_request}, 8'h02);

      // Asynchronous reset mid-operation
      bus.addr = A_PEND;
      tick(1); check("pre_rst_dout", bus.data_out, 8'h08);
      #3;
      reset = 1'b0;
      #1;
      check("mid_rst_irq", {4'h0, interrupt_request}, 8'h00);
      check("mid_rst_dout", bus.data_out, 8'h00);
      irq_src  = 8'h00;
      bus.addr = 8'h00;
      @(negedge clk);
      reset = 1'b1;
      rdreg(A_PEND, rd); check("post_rst_pend", rd, 8'h00);
      rdreg(A_MASK, rd); check("post_rst_mask", rd, 8'h00);
      rdreg(A_MODE, rd); check("post_rst_mode", rd, 8'h00);
      check("post_rst_irq", {4'h0, interrupt_request}, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reflet_irq_ctrl.md
# reflet_irq_ctrl

Memory-mapped interrupt controller between peripheral interrupt sources and the `interrupt_request[3:0]` input of `reflet_cpu`. It latches eight raw sources (edge- or level-sensitive per source), masks them, and funnels them onto the CPU's four request lines. The CPU configures and acknowledges it through four byte registers on its data bus. Sampling continues while the CPU is stalled (`enable` low), so no event is lost.

## Interface
- `wordsize`, default 8: CPU data/address width; must be ≥ 8.
- `base_addr`, default 'hF0: address of register offset 0; four consecutive addresses are decoded.

- `clk`  input  1  system clock, all state on rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = in reset).
- `enable`  input  1  CPU enable; 0 blocks register writes.
- `addr`  input  wordsize  CPU address bus.
- `data_in`  input  wordsize  write data (CPU `data_out`).
- `write_en`  input  1  CPU write strobe.
- `data_out`  output  wordsize  read data; 0 when not selected (bus-OR friendly).
- `irq_src`  input  8  asynchronous peripheral interrupt sources.
- `interrupt_request`  output  4  to CPU `interrupt_request`.

## Operation
- Register map, offset from `base_addr`. All values are zero-extended to wordsize on read.
  - 0 PENDING: read = pending[7:0]; write 1 = clear bit.
  - 1 MASK: read/write; 1 = enabled.
  - 2 MODE: read/write; 1 = rising-edge source, 0 = level source.
  - 3 STATUS: read-only.
    - bit7 = |(pending & MASK).
    - bits2:0 = lowest index set in (pending & MASK), 0 if none.
    - Writes to STATUS are ignored.
- Input path, per source:
  - Two-flop synchronizer s1→s2, plus history flop s3.
  - rise = s2 & !s3; level = s2.
  - set_i = MODE[i] ? rise : level.
- Pending update:
  - pending[i] <= set_i | (pending[i] & !clr_i).
  - clr_i = write to PENDING with data_in[i]=1 and enable=1.
  - When set and clear coincide, set wins.
  - A level source still high after its clear re-pends after one cycle.
- Routing: interrupt_request[j] <= |(pending[2j+1:2j] & MASK[2j+1:2j]), registered. Source 0/1 drives line 0, source 6/7 drives line 3.
- Writes take effect only when `write_en` & `enable` & address match. Unmatched addresses are ignored.
- Reset (async, `reset`=0) clears:
  - s1/s2/s3, pending, MASK and MODE to 0.
  - interrupt_request = 0, data_out = 0.
  - This holds even mid-operation; no event from before the reset survives it.

## Timing
- Source path latency:
  - irq_src is first sampled high at edge N.
  - s2 = 1 at N+1, pending = 1 at N+2.
  - interrupt_request = 1 at N+3 when masked in.
- Edge-mode pulses must be high ≥ 1 clk to be captured reliably. A pulse held many cycles sets pending once.
- Write latency:
  - MASK/MODE/PENDING-clear is written at edge W.
  - interrupt_request reflects the write at W+1 (registered output).
- Read latency:
  - data_out is registered from the address presented at edge R and valid after R, matching synchronous ROM timing.
  - data_out = 0 the cycle after a non-matching address.
- `enable`=0: synchronizer, pending set, routing and reads continue; only writes are suppressed.
- No internal state machine beyond the per-source flops; every output has a defined reset value.

## Test plan
- Reset values: hold reset=0, toggle irq_src and write_en → interrupt_request=0, data_out=0. After release, reads of PENDING/MASK/MODE/STATUS return 0.
- Edge capture: MODE='hFF, MASK='h01, irq_src[0] 0→1 sampled at N and held 20 clk → PENDING='h01 from N+2, interrupt_request='b0001 from N+3. Writing 'h01 to PENDING → request=0 one clk later with no re-pend.
- Level re-pend: MODE=0, MASK='h80, irq_src[7] held high, write 'h80 to PENDING → PENDING reads 'h80 again, interrupt_request[3] stays 1 or drops at most one cycle.
- Masking/priority: pend sources 2 and 5 with MASK='h20 → STATUS='h85, request='b0100. Set MASK='h24 → STATUS='h82, request='b0110.
- Stalled CPU: enable=0, pulse irq_src[1] for 5 clk, attempt a MASK write → event pends, MASK write ignored. After enable=1, PENDING='h02.
- Set/clear collision and mid-op reset: clear-write and a new edge on source 3 in the same cycle → pending[3] stays 1. Asserting reset mid-sequence → all registers and outputs return to 0 immediately (asynchronously).
